sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_pkg.sv | 15 +
 rtl/sw_debounce_ch.sv | 103 ++++++++++
 rtl/sw_debounce.sv | 29 ++
 tb/tb_sw_debounce.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM encoding
// and the default persistence window.
package sw_debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // The encoding keeps bit 1 equal to the debounced level.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } db_state_t;

endpackage

// File: rtl/sw_debounce_ch.sv
// One debounced switch channel: 2-flop synchronizer, level FSM and a
// saturating persistence counter with registered edge pulses.
module sw_debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_sw,
    output logic o_sw_stable,
    output logic o_sw_rise,
    output logic o_sw_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    db_state_t        state;
    db_state_t        next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             rise_q;
    logic             fall_q;
    logic             next_rise;
    logic             next_fall;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_sw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            rise_q <= next_rise;
            fall_q <= next_fall;
        end
    end

    // The counter only advances while the new level persists and is
    // cleared on commit, so it tops out at CNT_LAST and never wraps.
    always_comb begin
        next_state = state;
        next_cnt   = '0;
        next_rise  = 1'b0;
        next_fall  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (sync2) begin
                    next_state = WAIT_HI;
                    next_cnt   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!sync2) begin
                    next_state = STABLE_LO;
                end else if (cnt == CNT_LAST) begin
                    next_state = STABLE_HI;
                    next_rise  = 1'b1;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync2) begin
                    next_state = WAIT_LO;
                    next_cnt   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (sync2) begin
                    next_state = STABLE_HI;
                end else if (cnt == CNT_LAST) begin
                    next_state = STABLE_LO;
                    next_fall  = 1'b1;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            default: next_state = STABLE_LO;
        endcase
    end

    assign o_sw_stable = (state == STABLE_HI) || (state == WAIT_LO);
    assign o_sw_rise   = rise_q;
    assign o_sw_fall   = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: N_SW independent sw_debounce_ch lanes.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clock,
    input  logic            i_reset,
    input  logic [N_SW-1:0] i_sw,
    output logic [N_SW-1:0] o_sw_stable,
    output logic [N_SW-1:0] o_sw_rise,
    output logic [N_SW-1:0] o_sw_fall
);

    for (genvar g = 0; g < N_SW; g++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clock      (clock),
            .i_reset    (i_reset),
            .i_sw       (i_sw[g]),
            .o_sw_stable(o_sw_stable[g]),
            .o_sw_rise  (o_sw_rise[g]),
            .o_sw_fall  (o_sw_fall[g])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed scenarios plus random
// switch activity compared against a persistence-window reference model.
module tb_sw_debounce;

    localparam int N = 4;
    localparam int D = 16;

    logic         clock;
    logic         i_reset;
    logic [N-1:0] i_sw;
    logic [N-1:0] o_sw_stable;
    logic [N-1:0] o_sw_rise;
    logic [N-1:0] o_sw_fall;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: input seen two samples late, level accepted after
    // D consecutive samples that differ from the accepted level.
    logic [N-1:0] m_h1, m_h2, m_stable, m_rise, m_fall;
    int           m_run [N];

    sw_debounce #(
        .N_SW(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_sw       (i_sw),
        .o_sw_stable(o_sw_stable),
        .o_sw_rise  (o_sw_rise),
        .o_sw_fall  (o_sw_fall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
        for (int c = 0; c < N; c++) m_run[c] = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] sw);
        if (i_reset) begin
            model_reset();
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N; c++) begin
                if (m_h2[c] != m_stable[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_stable[c] = m_h2[c];
                        m_rise[c]   = m_h2[c];
                        m_fall[c]   = ~m_h2[c];
                        m_run[c]    = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_h2 = m_h1;
            m_h1 = sw;
        end
    endtask

    // Drive one clock cycle from a negedge to the next, checking the model.
    task automatic tick(input logic [N-1:0] sw);
        i_sw = sw;
        @(posedge clock);
        model_edge(sw);
        @(negedge clock);
        tests_run++;
        if ({o_sw_stable, o_sw_rise, o_sw_fall} !== {m_stable, m_rise, m_fall}) begin
            tests_failed++;
            $display("[TB] FAIL model at %0t: got stable=%b rise=%b fall=%b expected stable=%b rise=%b fall=%b",
                     $time, o_sw_stable, o_sw_rise, o_sw_fall, m_stable, m_rise, m_fall);
        end
    endtask

    task automatic settle(input logic [N-1:0] sw);
        for (int i = 0; i < D + 6; i++) tick(sw);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_sw    = 4'b1111;
        model_reset();
        #1;
        tests_run++;
        if ({o_sw_stable, o_sw_rise, o_sw_fall} !== 12'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: got %b expected 0", {o_sw_stable, o_sw_rise, o_sw_fall});
        end
        @(negedge clock);
        tick(4'b1111);
        tick(4'b1111);
        i_reset = 1'b0;
        for (int t = 1; t <= D + 2; t++) begin
            tick(4'b1111);
            if (t == D + 1) begin
                tests_run++;
                if (o_sw_stable !== 4'b0000) begin
                    tests_failed++;
                    $display("[TB] FAIL reset_release_early: got %b expected 0000", o_sw_stable);
                end
            end
            if (t == D + 2) begin
                tests_run++;
                if (o_sw_stable !== 4'b1111 || o_sw_rise !== 4'b1111) begin
                    tests_failed++;
                    $display("[TB] FAIL reset_release_rise: got stable=%b rise=%b expected 1111/1111",
                             o_sw_stable, o_sw_rise);
                end
            end
        end
        settle(4'b0000);
    endtask

    task automatic test_clean_step();
        for (int t = 1; t <= D + 3; t++) begin
            tick(4'b0101);
            if (t == D + 1) begin
                tests_run++;
                if (o_sw_stable !== 4'b0000) begin
                    tests_failed++;
                    $display("[TB] FAIL step_early: got %b expected 0000", o_sw_stable);
                end
            end
            if (t == D + 2) begin
                tests_run++;
                if (o_sw_stable !== 4'b0101 || o_sw_rise !== 4'b0101 || o_sw_fall !== 4'b0000) begin
                    tests_failed++;
                    $display("[TB] FAIL step_commit: got stable=%b rise=%b fall=%b expected 0101/0101/0000",
                             o_sw_stable, o_sw_rise, o_sw_fall);
                end
            end
            if (t == D + 3) begin
                tests_run++;
                if (o_sw_rise !== 4'b0000) begin
                    tests_failed++;
                    $display("[TB] FAIL step_pulse_width: got rise=%b expected 0000", o_sw_rise);
                end
            end
        end
        settle(4'b0000);
    endtask

    task automatic test_glitch();
        int bad = 0;
        for (int t = 0; t < 40; t++) begin
            tick((t < 10) ? 4'b0100 : 4'b0000);
            if (o_sw_stable[2] | o_sw_rise[2] | o_sw_fall[2]) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL glitch: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        int rise_at = -1;
        for (int t = 0; t < 60; t++) begin
            tick(((t / 3) % 2 == 0) ? 4'b0010 : 4'b0000);
            if (o_sw_rise[1] | o_sw_stable[1]) rises++;
        end
        for (int t = 1; t <= 30; t++) begin
            tick(4'b0010);
            if (o_sw_rise[1]) begin
                rises++;
                rise_at = t;
            end
        end
        tests_run++;
        if (rises !== 1 || rise_at !== D + 2) begin
            tests_failed++;
            $display("[TB] FAIL bounce: got %0d pulses at tick %0d expected 1 at tick %0d",
                     rises, rise_at, D + 2);
        end
        settle(4'b0000);
    endtask

    task automatic test_reset_mid_wait();
        int pulses = 0;
        for (int t = 0; t < 8; t++) tick(4'b1000);
        i_reset = 1'b1;
        #1;
        tests_run++;
        if (o_sw_stable !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL midwait_async: got %b expected 0000", o_sw_stable);
        end
        tick(4'b1000);
        tick(4'b1000);
        i_reset = 1'b0;
        for (int t = 1; t <= D + 2; t++) begin
            tick(4'b1000);
            if (t <= D + 1 && (o_sw_rise | o_sw_fall | o_sw_stable) != 0) pulses++;
        end
        tests_run++;
        if (pulses !== 0 || o_sw_stable !== 4'b1000 || o_sw_rise !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL midwait: got early=%0d stable=%b rise=%b expected 0/1000/1000",
                     pulses, o_sw_stable, o_sw_rise);
        end
        settle(4'b0000);
    endtask

    task automatic test_sequence();
        logic [N-1:0] seq [4];
        int bad = 0;
        seq[0] = 4'b0000; seq[1] = 4'b1111; seq[2] = 4'b0111; seq[3] = 4'b1111;
        for (int s = 1; s < 4; s++) begin
            for (int t = 1; t <= 30; t++) begin
                tick(seq[s]);
                if (o_sw_stable !== ((t >= D + 2) ? seq[s] : seq[s-1])) bad++;
            end
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL sequence: got %0d wrong cycles expected 0", bad);
        end
        settle(4'b0000);
    endtask

    task automatic test_random();
        logic [N-1:0] sw = '0;
        int overlap = 0;
        logic [N-1:0] prev_pulse = '0;
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 11) == 0) sw[c] = ~sw[c];
            tick(sw);
            if ((o_sw_rise & o_sw_fall) != 0 || ((o_sw_rise | o_sw_fall) & prev_pulse) != 0) overlap++;
            prev_pulse = o_sw_rise | o_sw_fall;
        end
        tests_run++;
        if (overlap !== 0) begin
            tests_failed++;
            $display("[TB] FAIL pulse_exclusive: got %0d violations expected 0", overlap);
        end
    endtask

    initial begin
        i_reset = 1'b0;
        i_sw    = '0;
        model_reset();
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_reset_mid_wait();
        test_sequence();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
